// File: rtl/ram_sdp_clr_bypass_if.sv
// ram_sdp_clr_bypass_if: bus of ram_sdp_clr_bypass; master drives port A write (ena/wea/wbe/addra/dia) and port B read (enb/addrb), slave returns dob/dob_valid/init_done
interface ram_sdp_clr_bypass_if #(
  parameter int DWIDTH = 64,
  parameter int DEPTH = 32
);
  localparam int NBYTES = DWIDTH / 8;
  localparam int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic ena;
  logic wea;
  logic [NBYTES-1:0] wbe;
  logic [AWIDTH-1:0] addra;
  logic [DWIDTH-1:0] dia;
  logic enb;
  logic [AWIDTH-1:0] addrb;
  logic [DWIDTH-1:0] dob;
  logic dob_valid;
  logic init_done;
  modport master (
    output ena, wea, wbe, addra, dia, enb, addrb,
    input dob, dob_valid, init_done
  );
  modport slave (
    input ena, wea, wbe, addra, dia, enb, addrb,
    output dob, dob_valid, init_done
  );
endinterface

// File: rtl/ram_sdp_clr_bypass.sv
// ram_sdp_clr_bypass: SDP RAM with byte enables, clear sweep, write-first bypass, optional output reg; ports clk, rst, bus (slave: port A write, port B read, dob/dob_valid/init_done)
module ram_sdp_clr_bypass #(
  parameter int DWIDTH = 64,
  parameter int DEPTH = 32,
  parameter bit OUT_REG = 1'b1,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input logic clk,
  input logic rst,
  ram_sdp_clr_bypass_if.slave bus
);
  localparam int NBYTES = DWIDTH / 8;
  localparam int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [AWIDTH-1:0] cnt, cnt_nx;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] wmask, rdata, d1;
  logic a_ok, b_ok, we, re, v1, out_upd;
  if (DEPTH == 2 ** AWIDTH) begin : g_pow2
    assign a_ok = 1'b1;
    assign b_ok = 1'b1;
  end else begin : g_npow2
    assign a_ok = 32'(bus.addra) < $unsigned(DEPTH);
    assign b_ok = 32'(bus.addrb) < $unsigned(DEPTH);
  end
  for (genvar i = 0; i < NBYTES; i++) begin : g_mask
    assign wmask[8*i +: 8] = {8{bus.wbe[i]}};
  end
  assign bus.init_done = state == RUN;
  assign we = bus.ena & bus.wea & bus.init_done & a_ok;
  assign re = bus.enb & bus.init_done;
  assign out_upd = OUT_REG ? v1 : re;
  always_comb begin
    state_nx = (state == CLEAR && cnt == AWIDTH'(DEPTH - 1)) ? RUN : state;
    cnt_nx = (state == CLEAR) ? cnt + 1'b1 : cnt;
    rdata = !b_ok ? '0
          : (we && bus.addra == bus.addrb) ? (bus.dia & wmask) | (mem[bus.addrb] & ~wmask)
          : mem[bus.addrb];
  end
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[cnt] <= INIT_VAL;
    else if (we)
      for (int i = 0; i < NBYTES; i++)
        if (bus.wbe[i]) mem[bus.addra][8*i +: 8] <= bus.dia[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      v1 <= 1'b0;
      d1 <= '0;
      bus.dob <= '0;
      bus.dob_valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      v1 <= re;
      if (re) d1 <= rdata;
      bus.dob_valid <= out_upd;
      if (out_upd) bus.dob <= OUT_REG ? d1 : rdata;
    end
  end
endmodule
